div_unit_64: RTL and testbench

- Multi-cycle 64-bit integer divider for the EX stage. Implements RV64 DIV, DIVU, REM and REMU.
- Its result is one of the two inputs to the EX result-select 64-bit 2:1 mux. The other input is the ALU result, and sel is driven by done.
- Hazard logic stalls the pipeline while busy=1.

---
 rtl/div_unit_64_pkg.sv | 22 ++
 rtl/div_step_64.sv | 35 +++
 rtl/div_unit_64.sv | 126 ++++++++++++
 tb/tb_div_unit_64.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/div_unit_64_pkg.sv
// Shared definitions for the 64-bit divider: widths, state encoding and
// special-case constants, plus a magnitude helper.
package div_unit_64_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [XLEN-1:0] DIV_ALL_ONES = '1;
  localparam logic [XLEN-1:0] INT_MIN_XLEN = {1'b1, {(XLEN-1){1'b0}}};

  // Absolute value when sgn is set; INT_MIN maps to 2^(XLEN-1) as unsigned.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic sgn);
    return (sgn && x[XLEN-1]) ? -x : x;
  endfunction

endpackage

// File: rtl/div_step_64.sv
// One restoring radix-2 division step (purely combinational).
// Ports:
//   rem      partial remainder (XLEN+1 bits)
//   quo      quotient/dividend shift register; MSB feeds the remainder
//   divisor  divisor magnitude
//   rem_next remainder after shift and conditional subtract
//   quo_next quotient after shift, LSB set when the subtract happened
module div_step_64
  import div_unit_64_pkg::*;
(
  input  logic [XLEN:0]   rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_next,
  output logic [XLEN-1:0] quo_next
);

  localparam int unsigned RW = XLEN + 1;

  // Shifted remainder carries one extra bit so the shift is lossless.
  logic [XLEN+1:0] rem_sh;
  logic            ge;

  always_comb begin
    rem_sh   = {rem, quo[XLEN-1]};
    ge       = (rem_sh >= {2'b00, divisor});
    rem_next = RW'(rem_sh);
    quo_next = {quo[XLEN-2:0], 1'b0};
    if (ge) begin
      rem_next    = RW'(rem_sh - {2'b00, divisor});
      quo_next[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_unit_64.sv
// Multi-cycle RV64 divider (DIV/DIVU/REM/REMU) for the EX stage.
// Ports:
//   clk, rst       clock, async active-high reset
//   start          request, sampled only in IDLE (ignored with flush)
//   is_signed      signed (DIV/REM) vs unsigned (DIVU/REMU)
//   is_rem         return remainder instead of quotient
//   dividend       operand A, captured on the start edge
//   divisor        operand B, captured on the start edge
//   flush          aborts the current operation
//   busy           high in BUSY and DONE
//   done           one-cycle pulse, result valid
//   result         quotient or remainder, held until overwritten
module div_unit_64
  import div_unit_64_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            is_signed,
  input  logic            is_rem,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN:0]   rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic            q_neg;
  logic            r_neg;
  logic            rem_sel;

  logic            div_zero_c;
  logic            ovf_c;
  logic [XLEN:0]   rem_nx;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] quo_fix_c;
  logic [XLEN-1:0] rem_fix_c;

  assign div_zero_c = (divisor == '0);
  assign ovf_c      = is_signed && (dividend == INT_MIN_XLEN) && (divisor == DIV_ALL_ONES);

  div_step_64 u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  // Sign fix applied to the final step's outputs; signs already include is_signed.
  assign quo_fix_c = q_neg ? -quo_nx : quo_nx;
  assign rem_fix_c = r_neg ? -rem_nx[XLEN-1:0] : rem_nx[XLEN-1:0];

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
      rem_sel <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && !flush) begin
            busy <= 1'b1;
            if (div_zero_c) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= is_rem ? dividend : DIV_ALL_ONES;
            end else if (ovf_c) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= is_rem ? '0 : INT_MIN_XLEN;
            end else begin
              state   <= BUSY;
              quo_q   <= mag(dividend, is_signed);
              dvs_q   <= mag(divisor, is_signed);
              q_neg   <= is_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
              r_neg   <= is_signed && dividend[XLEN-1];
              rem_sel <= is_rem;
              cnt     <= '0;
              rem_q   <= '0;
            end
          end
        end
        BUSY: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else begin
            rem_q <= rem_nx;
            quo_q <= quo_nx;
            cnt   <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(XLEN - 1)) begin
              state  <= DONE;
              done   <= 1'b1;
              result <= rem_sel ? rem_fix_c : quo_fix_c;
            end
          end
        end
        default: begin
          // DONE (or an illegal encoding): always back to IDLE, start ignored.
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit_64.sv
// Directed self-checking bench for div_unit_64.
module tb_div_unit_64;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic        is_rem;
  logic        flush;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        busy;
  logic        done;
  logic [63:0] result;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] INT_MIN = 64'h8000_0000_0000_0000;

  always #5 clk = ~clk;

  div_unit_64 dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .is_rem    (is_rem),
    .dividend  (dividend),
    .divisor   (divisor),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge, then scramble the operands.
  task automatic issue(input logic s, input logic r, input logic [63:0] a, input logic [63:0] b);
    start     = 1'b1;
    is_signed = s;
    is_rem    = r;
    dividend  = a;
    divisor   = b;
    tick();
    start     = 1'b0;
    is_signed = ~s;
    is_rem    = ~r;
    dividend  = ~a;
    divisor   = '0;
  endtask

  // Wait for done (latency counted in edges including the start edge),
  // optionally inject a start at BUSY cycle inj and/or in the DONE cycle.
  task automatic run(input string tag, input int exp_lat, input logic [63:0] exp_res,
                     input int inj, input bit start_in_done);
    int lat = 1;
    int busy_lo = 0;
    while (!done && lat < 200) begin
      if (!busy) busy_lo++;
      if (lat == inj) begin
        start = 1'b1; is_signed = 1'b0; is_rem = 1'b0; dividend = 64'd9; divisor = 64'd3;
      end else begin
        start = 1'b0;
      end
      tick();
      lat++;
    end
    start = 1'b0;
    if (!busy) busy_lo++;
    chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, " busy_low_cycles"}, 64'(busy_lo), 64'd0);
    chk({tag, " result"}, result, exp_res);
    if (start_in_done) begin
      start = 1'b1; is_signed = 1'b0; is_rem = 1'b0; dividend = 64'd9; divisor = 64'd3;
    end
    tick();
    start = 1'b0;
    chk({tag, " done_pulse_end"}, 64'(done), 64'd0);
    chk({tag, " busy_after"}, 64'(busy), 64'd0);
    chk({tag, " result_held"}, result, exp_res);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; flush = 1'b0; is_signed = 1'b0; is_rem = 1'b0;
    dividend = '0; divisor = '0;
    #12;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset result", result, 64'd0);
    rst = 1'b0;
    tick();

    issue(1'b0, 1'b0, 64'd100, 64'd7);
    run("divu 100/7", 65, 64'd14, 0, 1'b0);

    // Flush mid-BUSY: back to IDLE, no done, result untouched.
    issue(1'b0, 1'b0, 64'd1000, 64'd3);
    repeat (28) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush busy", 64'(busy), 64'd0);
    chk("flush done", 64'(done), 64'd0);
    chk("flush result", result, 64'd14);
    seen = 0;
    repeat (70) begin
      if (done) seen++;
      tick();
    end
    chk("flush no_done", 64'(seen), 64'd0);

    issue(1'b0, 1'b0, 64'd1000, 64'd3);
    run("divu 1000/3", 65, 64'd333, 0, 1'b0);

    // Asynchronous reset between edges mid-BUSY.
    issue(1'b0, 1'b0, 64'd77, 64'd5);
    repeat (10) tick();
    #3 rst = 1'b1;
    #1;
    chk("async rst busy", 64'(busy), 64'd0);
    chk("async rst done", 64'(done), 64'd0);
    chk("async rst result", result, 64'd0);
    #2 rst = 1'b0;
    tick();
    seen = 0;
    repeat (70) begin
      if (done) seen++;
      tick();
    end
    chk("async rst no_done", 64'(seen), 64'd0);
    issue(1'b0, 1'b0, 64'd77, 64'd5);
    run("divu 77/5", 65, 64'd15, 0, 1'b0);

    issue(1'b1, 1'b1, 64'(-100), 64'd7);
    run("rem -100/7", 65, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1'b0);
    issue(1'b1, 1'b0, 64'(-100), 64'd7);
    run("div -100/7", 65, 64'hFFFF_FFFF_FFFF_FFF2, 0, 1'b0);
    issue(1'b1, 1'b0, 64'd7, 64'(-2));
    run("div 7/-2", 65, 64'hFFFF_FFFF_FFFF_FFFD, 0, 1'b0);
    issue(1'b1, 1'b1, 64'd7, 64'(-2));
    run("rem 7/-2", 65, 64'd1, 0, 1'b0);
    issue(1'b0, 1'b0, INT_MIN, ONES);
    run("divu intmin/ones", 65, 64'd0, 0, 1'b0);
    issue(1'b0, 1'b1, ONES, 64'd10);
    run("remu ones/10", 65, 64'd5, 0, 1'b0);

    issue(1'b0, 1'b0, 64'd5, 64'd0);
    run("divu 5/0", 1, ONES, 0, 1'b0);
    issue(1'b0, 1'b1, 64'd5, 64'd0);
    run("remu 5/0", 1, 64'd5, 0, 1'b0);
    issue(1'b1, 1'b0, 64'(-5), 64'd0);
    run("div -5/0", 1, ONES, 0, 1'b0);
    issue(1'b1, 1'b1, 64'(-5), 64'd0);
    run("rem -5/0", 1, 64'hFFFF_FFFF_FFFF_FFFB, 0, 1'b0);

    issue(1'b1, 1'b0, INT_MIN, ONES);
    run("div overflow", 1, INT_MIN, 0, 1'b0);
    issue(1'b1, 1'b1, INT_MIN, ONES);
    run("rem overflow", 1, 64'd0, 0, 1'b0);

    // Starts during BUSY and in the DONE cycle are ignored.
    issue(1'b0, 1'b0, 64'd200, 64'd10);
    run("start while busy", 65, 64'd20, 5, 1'b1);
    tick();
    chk("ignored start no_busy", 64'(busy), 64'd0);
    chk("ignored start result", result, 64'd20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
